// File: rtl/riscv_pc_trap_unit.sv
// Next-PC and machine-mode trap unit: owns the PC, resolves branches/JAL/JALR,
// handles misaligned/illegal/ECALL/MRET traps and the EBREAK halt state.
module riscv_pc_trap_unit #(
   parameter int unsigned   XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter logic [XLEN-1:0] TRAP_VEC = XLEN'(32'h100)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            stall,
   input  logic            branch,
   input  logic            jal,
   input  logic            jalr,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1_val,
   input  logic [XLEN-1:0] rs2_val,
   input  logic [XLEN-1:0] imm,
   input  logic            ecall,
   input  logic            ebreak,
   input  logic            mret,
   input  logic            resume,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            taken,
   output logic            trap,
   output logic            commit,
   output logic [XLEN-1:0] mepc,
   output logic [3:0]      mcause,
   output logic            halted
);

   typedef enum logic {
      RUN    = 1'b0,
      HALTED = 1'b1
   } state_t;

   localparam logic [3:0] CAUSE_MISALIGNED = 4'd0;
   localparam logic [3:0] CAUSE_ILLEGAL    = 4'd2;
   localparam logic [3:0] CAUSE_BREAKPOINT = 4'd3;
   localparam logic [3:0] CAUSE_ECALL_M    = 4'd11;

   state_t          state, stateNext;
   logic [XLEN-1:0] pcNext, mepcNext;
   logic [3:0]      mcauseNext;
   logic [XLEN-1:0] pcPlus4, branchTarget, jalrTarget, target;
   logic            isEq, isLt, isLtu, condTrue, illegalF3;

   assign pcPlus4      = pc + XLEN'(4);
   assign branchTarget = pc + imm;
   assign jalrTarget   = (rs1_val + imm) & ~{{(XLEN-1){1'b0}}, 1'b1};

   assign isEq      = (rs1_val == rs2_val);
   assign isLt      = ($signed(rs1_val) < $signed(rs2_val));
   assign isLtu     = (rs1_val < rs2_val);
   assign illegalF3 = (funct3[2:1] == 2'b01);

   always_comb begin
      condTrue = 1'b0;
      case (funct3)
         3'b000:  condTrue = isEq;
         3'b001:  condTrue = ~isEq;
         3'b100:  condTrue = isLt;
         3'b101:  condTrue = ~isLt;
         3'b110:  condTrue = isLtu;
         3'b111:  condTrue = ~isLtu;
         default: condTrue = 1'b0;
      endcase
   end

   // JALR outranks JAL, which outranks a conditional branch
   always_comb begin
      if (jalr)
         target = jalrTarget;
      else
         target = branchTarget;
   end

   always_comb begin
      stateNext  = state;
      pcNext     = pc;
      mepcNext   = mepc;
      mcauseNext = mcause;
      taken      = 1'b0;
      trap       = 1'b0;
      commit     = 1'b0;

      if (!reset && !stall) begin
         case (state)
            RUN: begin
               commit = 1'b1;
               pcNext = pcPlus4;
               if (branch && illegalF3) begin
                  trap       = 1'b1;
                  mcauseNext = CAUSE_ILLEGAL;
                  mepcNext   = pc;
                  pcNext     = TRAP_VEC;
               end else if (ecall) begin
                  trap       = 1'b1;
                  mcauseNext = CAUSE_ECALL_M;
                  mepcNext   = pc;
                  pcNext     = TRAP_VEC;
               end else if (ebreak) begin
                  mcauseNext = CAUSE_BREAKPOINT;
                  mepcNext   = pc;
                  pcNext     = pc;
                  stateNext  = HALTED;
               end else if (mret) begin
                  taken  = 1'b1;
                  pcNext = mepc;
               end else if (jalr || jal || (branch && condTrue)) begin
                  if (target[1:0] != 2'b00) begin
                     trap       = 1'b1;
                     mcauseNext = CAUSE_MISALIGNED;
                     mepcNext   = pc;
                     pcNext     = TRAP_VEC;
                  end else begin
                     taken  = 1'b1;
                     pcNext = target;
                  end
               end
               commit = ~trap & ~ebreak;
            end
            HALTED: begin
               if (resume) begin
                  pcNext    = pcPlus4;
                  stateNext = RUN;
               end
            end
            default: stateNext = RUN;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= RUN;
         pc     <= RESET_PC;
         mepc   <= '0;
         mcause <= '0;
      end else begin
         state  <= stateNext;
         pc     <= pcNext;
         mepc   <= mepcNext;
         mcause <= mcauseNext;
      end
   end

   assign pc_plus4 = pcPlus4;
   assign halted   = (state == HALTED);

endmodule

// File: tb/tb_riscv_pc_trap_unit.sv
// Directed bench for riscv_pc_trap_unit: expected outcomes queued per step and
// compared combinationally before the edge and as registered state after it.
module tb_riscv_pc_trap_unit;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall, branch, jal, jalr, ecall, ebreak, mret, resume;
   logic [2:0]  funct3;
   logic [31:0] rs1_val, rs2_val, imm;
   logic [31:0] pc, pc_plus4, mepc;
   logic        taken, trap, commit, halted;
   logic [3:0]  mcause;

   int unsigned checks = 0;
   int unsigned errors = 0;

   typedef struct {
      string       tag;
      logic        tk, tr, cm;
      logic [31:0] p4, pcN, mepcN;
      logic [3:0]  mcN;
      logic        hlN;
   } exp_t;

   exp_t sb[$];

   riscv_pc_trap_unit #(.XLEN(32), .RESET_PC(32'h0), .TRAP_VEC(32'h100)) dut (
      .clk(clk), .reset(reset), .stall(stall), .branch(branch), .jal(jal),
      .jalr(jalr), .funct3(funct3), .rs1_val(rs1_val), .rs2_val(rs2_val),
      .imm(imm), .ecall(ecall), .ebreak(ebreak), .mret(mret), .resume(resume),
      .pc(pc), .pc_plus4(pc_plus4), .taken(taken), .trap(trap),
      .commit(commit), .mepc(mepc), .mcause(mcause), .halted(halted)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic clearIn();
      stall = 0; branch = 0; jal = 0; jalr = 0; ecall = 0; ebreak = 0;
      mret = 0; resume = 0; funct3 = 3'b000;
      rs1_val = '0; rs2_val = '0; imm = '0;
   endtask

   // Inputs are already driven; queue the expectation, then check both phases.
   task automatic run(input string tag, input logic tk, input logic tr, input logic cm,
                      input logic [31:0] p4, input logic [31:0] pcN,
                      input logic [31:0] mepcN, input logic [3:0] mcN, input logic hlN);
      exp_t e;
      e.tag = tag; e.tk = tk; e.tr = tr; e.cm = cm; e.p4 = p4;
      e.pcN = pcN; e.mepcN = mepcN; e.mcN = mcN; e.hlN = hlN;
      sb.push_back(e);
      #2;
      e = sb.pop_front();
      chk({e.tag, ".taken"},  32'(taken),    32'(e.tk));
      chk({e.tag, ".trap"},   32'(trap),     32'(e.tr));
      chk({e.tag, ".commit"}, 32'(commit),   32'(e.cm));
      chk({e.tag, ".pc4"},    pc_plus4,      e.p4);
      @(posedge clk);
      #1;
      chk({e.tag, ".pc"},     pc,            e.pcN);
      chk({e.tag, ".mepc"},   mepc,          e.mepcN);
      chk({e.tag, ".mcause"}, 32'(mcause),   32'(e.mcN));
      chk({e.tag, ".halted"}, 32'(halted),   32'(e.hlN));
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      clearIn();
      reset = 1;
      jal = 1; imm = 32'h10;
      #2;
      chk("rst.pc", pc, 32'h0);
      chk("rst.taken", 32'(taken), 32'h0);
      chk("rst.commit", 32'(commit), 32'h0);
      chk("rst.mepc", mepc, 32'h0);
      chk("rst.halted", 32'(halted), 32'h0);
      @(negedge clk); reset = 0; clearIn();

      run("seq0", 0, 0, 1, 32'h4,  32'h4,  32'h0, 4'd0, 0);
      @(negedge clk); clearIn();
      run("seq1", 0, 0, 1, 32'h8,  32'h8,  32'h0, 4'd0, 0);
      @(negedge clk); clearIn();
      run("seq2", 0, 0, 1, 32'hC,  32'hC,  32'h0, 4'd0, 0);

      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b100;
      rs1_val = 32'hFFFF_FFFF; rs2_val = 32'h1; imm = 32'h10;
      run("blt", 1, 0, 1, 32'h10, 32'h1C, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b110;
      rs1_val = 32'hFFFF_FFFF; rs2_val = 32'h1; imm = 32'h10;
      run("bltu", 0, 0, 1, 32'h20, 32'h20, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b000;
      rs1_val = 32'h5; rs2_val = 32'h5; imm = 32'hFFFF_FFF8;
      run("beq", 1, 0, 1, 32'h24, 32'h18, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b010;
      run("illf3", 0, 1, 0, 32'h1C, 32'h100, 32'h18, 4'd2, 0);

      @(negedge clk); clearIn(); jal = 1; imm = 32'hFFFF_FF40;
      run("jal40a", 1, 0, 1, 32'h104, 32'h40, 32'h18, 4'd2, 0);
      @(negedge clk); clearIn(); jalr = 1; rs1_val = 32'h201; imm = 32'h2;
      run("jalrmis", 0, 1, 0, 32'h44, 32'h100, 32'h40, 4'd0, 0);
      @(negedge clk); clearIn(); jal = 1; imm = 32'hFFFF_FF40;
      run("jal40b", 1, 0, 1, 32'h104, 32'h40, 32'h40, 4'd0, 0);
      @(negedge clk); clearIn(); jalr = 1; rs1_val = 32'h201; imm = 32'h3;
      run("jalrok", 1, 0, 1, 32'h44, 32'h204, 32'h40, 4'd0, 0);

      @(negedge clk); clearIn(); jal = 1; imm = 32'hFFFF_FE7C;
      run("jal80", 1, 0, 1, 32'h208, 32'h80, 32'h40, 4'd0, 0);
      @(negedge clk); clearIn(); ecall = 1;
      run("ecall", 0, 1, 0, 32'h84, 32'h100, 32'h80, 4'd11, 0);
      @(negedge clk); clearIn(); mret = 1;
      run("mret", 1, 0, 1, 32'h104, 32'h80, 32'h80, 4'd11, 0);

      @(negedge clk); clearIn(); jal = 1; imm = 32'hFFFF_FFB0;
      run("jal30", 1, 0, 1, 32'h84, 32'h30, 32'h80, 4'd11, 0);
      @(negedge clk); clearIn(); ebreak = 1;
      run("ebreak", 0, 0, 0, 32'h34, 32'h30, 32'h30, 4'd3, 1);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); clearIn(); jal = 1; imm = 32'h10;
         run("haltjal", 0, 0, 0, 32'h34, 32'h30, 32'h30, 4'd3, 1);
      end
      @(negedge clk); clearIn(); resume = 1;
      run("resume", 0, 0, 0, 32'h34, 32'h34, 32'h30, 4'd3, 0);

      @(negedge clk); clearIn(); stall = 1; jal = 1; imm = 32'h10;
      run("stall", 0, 0, 0, 32'h38, 32'h34, 32'h30, 4'd3, 0);
      @(negedge clk); clearIn(); ecall = 1; jal = 1; imm = 32'h10;
      run("ecalljal", 0, 1, 0, 32'h38, 32'h100, 32'h34, 4'd11, 0);

      @(negedge clk); clearIn(); jal = 1; imm = 32'hFFFF_FEFC;
      run("jaltop", 1, 0, 1, 32'h104, 32'hFFFF_FFFC, 32'h34, 4'd11, 0);
      @(negedge clk); clearIn();
      run("wrap", 0, 0, 1, 32'h0, 32'h0, 32'h34, 4'd11, 0);
      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b001;
      rs1_val = 32'h1; rs2_val = 32'h2; imm = 32'h6;
      run("bnemis", 0, 1, 0, 32'h4, 32'h100, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); branch = 1; funct3 = 3'b000;
      rs1_val = 32'h1; rs2_val = 32'h2; imm = 32'h6;
      run("beqnt", 0, 0, 1, 32'h104, 32'h104, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); resume = 1;
      run("resrun", 0, 0, 1, 32'h108, 32'h108, 32'h0, 4'd0, 0);
      @(negedge clk); clearIn(); ebreak = 1;
      run("ebreak2", 0, 0, 0, 32'h10C, 32'h108, 32'h108, 4'd3, 1);

      @(negedge clk); clearIn(); jal = 1; imm = 32'h10; reset = 1;
      #2;
      chk("rsthalt.pc", pc, 32'h0);
      chk("rsthalt.halted", 32'(halted), 32'h0);
      chk("rsthalt.mcause", 32'(mcause), 32'h0);
      chk("rsthalt.taken", 32'(taken), 32'h0);
      chk("rsthalt.commit", 32'(commit), 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/riscv_pc_trap_unit.md
# riscv_pc_trap_unit

Parametrised next-PC and trap unit for the single-cycle RISC-V core; replaces the inline next-PC logic of the top level. It owns the PC register and resolves all six RV32I conditional branches, JAL and JALR. It adds machine-mode trap handling (misaligned target, illegal branch funct3, ECALL, MRET) and an EBREAK halt/resume state, with mepc/mcause state. It sits between decode (control and immediate inputs), the register file (rs1/rs2 values) and instruction fetch (pc output).

## Interface
- XLEN, 32: datapath/PC width (≥8).
- RESET_PC, 0: PC value loaded on reset.
- TRAP_VEC, 32'h100: PC loaded on any trap; must be 4-byte aligned.
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high.
- stall  in  1  hold all state this cycle.
- branch  in  1  conditional branch instruction.
- jal  in  1  JAL instruction.
- jalr  in  1  JALR instruction.
- funct3  in  3  branch condition select.
- rs1_val  in  XLEN  register rs1 value.
- rs2_val  in  XLEN  register rs2 value.
- imm  in  XLEN  sign-extended immediate.
- ecall, ebreak, mret  in  1 each  system instruction decodes.
- resume  in  1  leave HALTED (single-cycle pulse).
- pc  out  XLEN  current PC (registered).
- pc_plus4  out  XLEN  pc+4, link value for JAL/JALR.
- taken  out  1  control transfer taken this cycle (combinational).
- trap  out  1  current instruction traps (combinational).
- commit  out  1  current instruction retires; gates regfile/memory writes.
- mepc  out  XLEN  saved exception PC (registered).
- mcause  out  4  saved cause code (registered).
- halted  out  1  unit in HALTED state.

## Operation
- States: RUN, HALTED. Reset → RUN.
- Branch condition by funct3: 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE. 010/011 → illegal.
- Targets, modulo 2^XLEN: branch/JAL = pc+imm; JALR = (rs1_val+imm) with bit 0 cleared.
- Misaligned: a taken target with bits[1:0]≠0 traps.
- RUN, not stalled; first match wins:
  1. branch with illegal funct3: trap, mcause=2, mepc=pc, pc←TRAP_VEC.
  2. ecall: trap, mcause=11, mepc=pc, pc←TRAP_VEC.
  3. ebreak: mcause=3, mepc=pc, pc holds, state→HALTED. trap=0, commit=0.
  4. mret: pc←mepc, taken=1.
  5. jalr / jal / taken branch, in that order: taken=1. If aligned, pc←target. If misaligned: trap, mcause=0, mepc=pc, pc←TRAP_VEC, taken=0.
  6. Otherwise: pc←pc+4.
- commit = RUN & ~stall & ~trap & ~ebreak.
- HALTED: all control inputs ignored; commit=0, taken=0, trap=0. resume (not stalled) → pc←pc+4, state→RUN. resume in RUN is ignored.
- stall: pc, mepc, mcause and state hold; taken, trap and commit forced 0.

## Timing
- One instruction per cycle. All state updates at the rising clk edge. taken, trap, commit and pc_plus4 are combinational in the same cycle as the instruction.
- Reset values: pc=RESET_PC, mepc=0, mcause=0, halted=0, state RUN. taken, trap and commit are 0 while reset is asserted.
- Reset mid-operation (including in HALTED) takes effect immediately and asynchronously; any pending update is lost.
- pc+4 and all targets wrap silently at 2^XLEN; wrap is not a trap.
- Simultaneous asserted controls resolve by the priority above; lower-priority inputs are ignored.

## Test plan
- Reset and sequential: reset with RESET_PC=0, release, 3 cycles no control → pc=0,4,8,12; commit=1 each cycle.
- Branch conditions: rs1=32'hFFFF_FFFF, rs2=1, imm=16. BLT → taken, pc+16. BLTU → not taken, pc+4. BEQ with equal operands → taken. funct3=010 → trap, mcause=2, pc=32'h100.
- JALR alignment: at pc=0x40, rs1=0x201, imm=2 → target 0x202, misaligned → trap, mcause=0, mepc=0x40, pc=0x100, commit=0. Then rs1=0x201, imm=3 → pc=0x204, pc_plus4=0x44 during the JALR cycle.
- ECALL/MRET: ecall at pc=0x80 → mepc=0x80, mcause=11, pc=0x100. Next cycle mret → pc=0x80.
- EBREAK halt: ebreak at pc=0x30 → halted=1, pc stays 0x30 for 5 cycles with jal asserted (ignored). resume → pc=0x34, halted=0.
- Stall and priority: stall with jal → pc, mepc and mcause unchanged, commit=0. ecall+jal together → trap path. Reset asserted while HALTED → pc=RESET_PC, halted=0 immediately.
